io_bus_bridge: RTL

CPU-side bridge that sits directly upstream of the IO port bank. It accepts single memory-mapped read/write requests from the CPU over a req/ack handshake and decodes the IO address window. It sequences the port bank's en / r_or_w / io_addr / data_in strobes with a setup cycle, captures the port bank's negedge-registered read data, and returns it with an ack. Out-of-window and out-of-range accesses complete with an error and never strobe the port bank.

---
 rtl/io_bus_bridge.sv | 80 ++++++++
 1 files changed

// File: rtl/io_bus_bridge.sv
// io_bus_bridge: decodes CPU req/ack accesses into the IO port bank window and
// sequences setup/enable strobes, returning read data or an error with the ack.
module io_bus_bridge #(
    parameter int                BITS     = 16,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] IO_BASE  = 16'hFF00,
    parameter int                IO_PORTS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [BITS-1:0]   cpu_wdata,
    output logic              cpu_ack,
    output logic [BITS-1:0]   cpu_rdata,
    output logic              cpu_err,
    output logic              busy,
    output logic [7:0]        err_cnt,
    output logic              io_en,
    output logic              io_r_or_w,
    output logic [3:0]        io_addr,
    output logic [BITS-1:0]   io_data_in,
    input  logic [BITS-1:0]   io_data_out
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    localparam logic [4:0] NPORTS = 5'(IO_PORTS);
    state_t r_state;
    logic   w_ok;
    assign w_ok = (cpu_addr[ADDR_W-1:4] == IO_BASE[ADDR_W-1:4]) && ({1'b0, cpu_addr[3:0]} < NPORTS);
    assign busy = r_state != IDLE;
    // io_* outputs double as the latched request; the error path never touches them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            cpu_ack    <= 1'b0;
            cpu_err    <= 1'b0;
            cpu_rdata  <= '0;
            err_cnt    <= '0;
            io_en      <= 1'b0;
            io_r_or_w  <= 1'b0;
            io_addr    <= '0;
            io_data_in <= '0;
        end else begin
            case (r_state)
                IDLE: if (cpu_req) begin
                    if (w_ok) begin
                        r_state    <= SETUP;
                        io_addr    <= cpu_addr[3:0];
                        io_r_or_w  <= cpu_we;
                        io_data_in <= cpu_we ? cpu_wdata : '0;
                    end else begin
                        r_state   <= RESP;
                        cpu_ack   <= 1'b1;
                        cpu_err   <= 1'b1;
                        cpu_rdata <= '0;
                        err_cnt   <= err_cnt + 8'(err_cnt != 8'hFF);
                    end
                end
                SETUP: begin
                    r_state <= ACCESS;
                    io_en   <= 1'b1;
                end
                ACCESS: begin
                    r_state   <= RESP;
                    io_en     <= 1'b0;
                    cpu_ack   <= 1'b1;
                    cpu_err   <= 1'b0;
                    cpu_rdata <= io_r_or_w ? '0 : io_data_out;
                end
                default: begin
                    r_state   <= IDLE;
                    cpu_ack   <= 1'b0;
                    cpu_err   <= 1'b0;
                    cpu_rdata <= '0;
                end
            endcase
        end
    end
endmodule
